// File: rtl/except_unit_pkg.sv
// Shared definitions for the MEM-stage precise-exception unit: exception codes,
// redirect vector, mem_flags bit positions and the interrupt-pending rule.
package except_unit_pkg;

    localparam logic [31:0] EXC_VECTOR = 32'hBFC00380;

    localparam logic [31:0] EXC_NONE = 32'h0;
    localparam logic [31:0] EXC_INT  = 32'h1;
    localparam logic [31:0] EXC_ADEL = 32'h4;
    localparam logic [31:0] EXC_ADES = 32'h5;
    localparam logic [31:0] EXC_SYS  = 32'h8;
    localparam logic [31:0] EXC_BP   = 32'h9;
    localparam logic [31:0] EXC_RI   = 32'ha;
    localparam logic [31:0] EXC_OV   = 32'hc;
    localparam logic [31:0] EXC_TR   = 32'hd;
    localparam logic [31:0] EXC_ERET = 32'he;

    localparam int F_ADEL_FETCH = 0;
    localparam int F_RI         = 1;
    localparam int F_OV         = 2;
    localparam int F_TRAP       = 3;
    localparam int F_SYSCALL    = 4;
    localparam int F_BRK        = 5;
    localparam int F_ADEL_DATA  = 6;
    localparam int F_ADES       = 7;
    localparam int F_ERET       = 8;

    localparam int MEM_STALL_IDX = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        TAKEN = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        BV_NONE = 2'd0,
        BV_PC   = 2'd1,
        BV_DATA = 2'd2
    } bv_sel_e;

    // IE set, EXL clear, and some enabled IP line raised (timer folds into IP7).
    function automatic logic int_pending(input logic [7:0] ip_raw, input logic timer,
                                         input logic [7:0] im, input logic ie,
                                         input logic exl);
        logic [7:0] ip;
        ip = {ip_raw[7] | timer, ip_raw[6:0]};
        return ie & ~exl & (|(ip & im));
    endfunction

endpackage

// File: rtl/except_prio.sv
// Fixed-priority exception encoder: interrupt first, then sync flags in the
// order fetch AdEL, RI, Ov, Tr, Sys, Bp, data AdEL, AdES, ERET.
module except_prio
    import except_unit_pkg::*;
(
    input  logic [8:0]  flags,
    input  logic        int_req,
    output logic [31:0] code,
    output bv_sel_e     bv_sel
);

    always_comb begin
        code   = EXC_NONE;
        bv_sel = BV_NONE;
        if (int_req) begin
            code = EXC_INT;
        end else if (flags[F_ADEL_FETCH]) begin
            code   = EXC_ADEL;
            bv_sel = BV_PC;
        end else if (flags[F_RI]) begin
            code = EXC_RI;
        end else if (flags[F_OV]) begin
            code = EXC_OV;
        end else if (flags[F_TRAP]) begin
            code = EXC_TR;
        end else if (flags[F_SYSCALL]) begin
            code = EXC_SYS;
        end else if (flags[F_BRK]) begin
            code = EXC_BP;
        end else if (flags[F_ADEL_DATA]) begin
            code   = EXC_ADEL;
            bv_sel = BV_DATA;
        end else if (flags[F_ADES]) begin
            code   = EXC_ADES;
            bv_sel = BV_DATA;
        end else if (flags[F_ERET]) begin
            code = EXC_ERET;
        end
    end

endmodule

// File: rtl/except_unit.sv
// MEM-stage commit unit: picks one exception per instruction, registers the
// CP0 bundle and issues a one-cycle flush with the redirect PC.
module except_unit
    import except_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  stall,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic        mem_in_delayslot,
    input  logic [8:0]  mem_flags,
    input  logic [31:0] mem_bad_vaddr,
    input  logic [31:0] status_i,
    input  logic [31:0] cause_i,
    input  logic [31:0] epc_i,
    input  logic        timer_int_i,
    output logic [31:0] excepttype_o,
    output logic [31:0] pc_o,
    output logic [31:0] bad_vaddr_o,
    output logic        is_in_delayslot_o,
    output logic        flush_o,
    output logic [31:0] new_pc_o,
    output state_e      state
);

    logic        decode_en;
    logic        int_req;
    logic [8:0]  flags_gated;
    logic [31:0] code;
    bv_sel_e     bv_sel;
    logic [31:0] bv_next;
    logic        unused_bits;

    assign unused_bits = ^{stall[5], stall[3:0], status_i[31:16], status_i[7:2],
                           cause_i[31:16], cause_i[7:0]};

    // In TAKEN the MEM instruction is being flushed, so nothing is decoded.
    assign decode_en   = (state == IDLE) && mem_valid && !stall[MEM_STALL_IDX];
    assign int_req     = decode_en && int_pending(cause_i[15:8], timer_int_i,
                                                  status_i[15:8], status_i[0], status_i[1]);
    assign flags_gated = decode_en ? mem_flags : 9'd0;

    except_prio u_prio (
        .flags   (flags_gated),
        .int_req (int_req),
        .code    (code),
        .bv_sel  (bv_sel)
    );

    always_comb begin
        bv_next = 32'd0;
        case (bv_sel)
            BV_PC:   bv_next = mem_pc;
            BV_DATA: bv_next = mem_bad_vaddr;
            default: bv_next = 32'd0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= IDLE;
            excepttype_o      <= EXC_NONE;
            pc_o              <= 32'd0;
            bad_vaddr_o       <= 32'd0;
            is_in_delayslot_o <= 1'b0;
            flush_o           <= 1'b0;
            new_pc_o          <= 32'd0;
        end else begin
            excepttype_o      <= EXC_NONE;
            pc_o              <= 32'd0;
            bad_vaddr_o       <= 32'd0;
            is_in_delayslot_o <= 1'b0;
            flush_o           <= 1'b0;
            new_pc_o          <= 32'd0;
            case (state)
                IDLE: begin
                    if (code != EXC_NONE) begin
                        state             <= TAKEN;
                        excepttype_o      <= code;
                        pc_o              <= mem_pc;
                        bad_vaddr_o       <= bv_next;
                        is_in_delayslot_o <= mem_in_delayslot;
                        flush_o           <= 1'b1;
                        new_pc_o          <= (code == EXC_ERET) ? epc_i : EXC_VECTOR;
                    end
                end
                TAKEN: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
